// File: rtl/sdm_dac_tx.sv
// Sigma-delta DAC transmit path: input FIFO, sample-rate timer and first-order
// modulator producing a 1-bit bitstream for an external low-pass filter.
module sdm_dac_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned OSR_LOG2   = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [WIDTH-1:0]              s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          dac_out,
  output logic                          underrun,
  input  logic                          clr_underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [OSR_LOG2-1:0] cnt;
  logic [WIDTH-1:0]    cur;
  logic [WIDTH:0]      acc;

  logic                tick_c;
  logic                empty_c;
  logic                push_c;
  logic                pop_c;
  logic [WIDTH:0]      sum_c;
  logic [LW-1:0]       level_nxt_c;

  assign tick_c  = en && (cnt == '1);
  assign empty_c = (fifo_level == '0);
  assign push_c  = s_valid && s_ready;
  assign pop_c   = tick_c && !empty_c;
  assign sum_c   = {1'b0, acc[WIDTH-1:0]} + {1'b0, cur};

  // The carry of the last accumulation is the bitstream bit itself.
  assign dac_out = acc[WIDTH];

  always_comb begin
    level_nxt_c = fifo_level + LW'(push_c) - LW'(pop_c);
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers, occupancy and a registered ready that only sees state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      s_ready    <= 1'b1;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_level <= level_nxt_c;
      s_ready    <= (level_nxt_c != LW'(FIFO_DEPTH));
    end
  end

  // Sample-rate timer; restarts from zero whenever the path is idle.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + OSR_LOG2'(1);
    end
  end

  // Current sample: loaded at a tick, held across underruns and idle time.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= '0;
    end else if (pop_c) begin
      cur <= mem[rd_ptr];
    end
  end

  // Sticky underrun; a new event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (tick_c && empty_c) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end

  // First-order modulator; idle forces the accumulator and output low.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      acc <= '0;
    end else begin
      acc <= sum_c;
    end
  end

endmodule
